uart_rx: RTL and testbench

UART receiver: deserialises an asynchronous 8N1-style serial line into parallel payload words for the SumLatch datapath. It pairs with the system UART transmitter; parameter defaults match so one parameter set configures both ends of the link. The block double-flop synchronises the line, detects and qualifies the start bit, samples each bit at mid-bit, and checks framing. It reports each received word with a one-cycle valid strobe, plus framing-error and break indications.

---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART link: the serial line and enable in,
// the decoded payload and its status strobes out.
interface uart_rx_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_frame_err;
  logic                    uart_rx_break;

  modport master (
    input  uart_rxd,
    input  uart_rx_en,
    output uart_rx_valid,
    output uart_rx_data,
    output uart_rx_frame_err,
    output uart_rx_break
  );

  modport slave (
    output uart_rxd,
    output uart_rx_en,
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_rx_frame_err,
    input  uart_rx_break
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, qualifies the start bit,
// samples each bit at mid-bit and reports good frames, framing errors and breaks.
module uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_rx_if.master bus
);

  localparam int CPB  = (1_000_000_000 / BIT_RATE) / (1_000_000_000 / CLK_HZ);
  localparam int HALF = CPB / 2;
  localparam int CW   = 1 + $clog2(CPB);
  localparam int BW   = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CW-1:0] CPB_M1   = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);

  // Only one stop bit is checked; any further ones look like idle line.
  if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8 || STOP_BITS < 1) begin : g_bad_params
    $error("uart_rx: unsupported PAYLOAD_BITS or STOP_BITS");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RECV  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic                    rxd_s1;
  logic                    rxd_s;
  state_t                  state_r;
  logic [CW-1:0]           cyc_cnt_r;
  logic [BW-1:0]           bit_cnt_r;
  logic [PAYLOAD_BITS-1:0] shift_r;
  logic [PAYLOAD_BITS-1:0] data_r;
  logic                    wait_high_r;
  logic                    valid_r;
  logic                    frame_err_r;
  logic                    break_r;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_s1 <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      rxd_s1 <= bus.uart_rxd;
      rxd_s  <= rxd_s1;
    end
  end

  // Frame FSM with registered payload and one-cycle status strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cyc_cnt_r   <= {CW{1'b0}};
      bit_cnt_r   <= {BW{1'b0}};
      shift_r     <= {PAYLOAD_BITS{1'b0}};
      data_r      <= {PAYLOAD_BITS{1'b0}};
      wait_high_r <= 1'b0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      break_r     <= 1'b0;
    end else begin
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      break_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          cyc_cnt_r <= {CW{1'b0}};
          bit_cnt_r <= {BW{1'b0}};
          // After a framing error the line must return high before a new start.
          if (wait_high_r) begin
            if (rxd_s) begin
              wait_high_r <= 1'b0;
            end else begin
              wait_high_r <= 1'b1;
            end
          end else if (bus.uart_rx_en && !rxd_s) begin
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (cyc_cnt_r == HALF_M1) begin
            cyc_cnt_r <= {CW{1'b0}};
            state_r   <= rxd_s ? IDLE : RECV;
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
          end
        end
        RECV: begin
          if (cyc_cnt_r == CPB_M1) begin
            cyc_cnt_r <= {CW{1'b0}};
            shift_r   <= {rxd_s, shift_r[PAYLOAD_BITS-1:1]};
            bit_cnt_r <= bit_cnt_r + BIT_ONE;
            if (bit_cnt_r == LAST_BIT) begin
              state_r <= STOP;
            end else begin
              state_r <= RECV;
            end
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
          end
        end
        STOP: begin
          if (cyc_cnt_r == CPB_M1) begin
            cyc_cnt_r <= {CW{1'b0}};
            state_r   <= IDLE;
            if (rxd_s) begin
              data_r  <= shift_r;
              valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
              break_r     <= (shift_r == {PAYLOAD_BITS{1'b0}});
              wait_high_r <= 1'b1;
            end
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          cyc_cnt_r <= {CW{1'b0}};
          bit_cnt_r <= {BW{1'b0}};
        end
      endcase
    end
  end

  assign bus.uart_rx_valid     = valid_r;
  assign bus.uart_rx_data      = data_r;
  assign bus.uart_rx_frame_err = frame_err_r;
  assign bus.uart_rx_break     = break_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 1 Mbit/s (50 cycles per bit).
module tb_uart_rx;

  localparam int CPB = 50;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_valid = 0;
  int   n_err = 0;
  int   n_brk = 0;
  int   n_brk_alone = 0;
  int   last_valid_cyc = 0;
  int   start_cyc = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_rx_if #(.PAYLOAD_BITS(8)) rx_if();

  uart_rx #(
    .BIT_RATE    (1_000_000),
    .CLK_HZ      (50_000_000),
    .PAYLOAD_BITS(8),
    .STOP_BITS   (1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (rx_if)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_if.uart_rx_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      rx_q.push_back(rx_if.uart_rx_data);
    end
    if (rx_if.uart_rx_frame_err) n_err++;
    if (rx_if.uart_rx_break) n_brk++;
    if (rx_if.uart_rx_break && !rx_if.uart_rx_frame_err) n_brk_alone++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_lvl);
    start_cyc = cyc;
    rx_if.uart_rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_if.uart_rxd = d[i];
      idle(CPB);
    end
    rx_if.uart_rxd = stop_lvl;
    idle(CPB);
    rx_if.uart_rxd = 1'b1;
  endtask

  function automatic logic [31:0] next_word();
    if (rx_q.size() > 0) return {24'h0, rx_q.pop_front()};
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, e0, b0, lat;
    reset_n          = 1'b1;
    rx_if.uart_rxd   = 1'b1;
    rx_if.uart_rx_en = 1'b1;
    #2 reset_n = 1'b0;

    // Reset held with the line toggling.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx_if.uart_rxd = ~rx_if.uart_rxd;
    end
    check_eq("rst_valid", {31'h0, rx_if.uart_rx_valid}, 32'h0);
    check_eq("rst_err",   {31'h0, rx_if.uart_rx_frame_err}, 32'h0);
    check_eq("rst_break", {31'h0, rx_if.uart_rx_break}, 32'h0);
    check_eq("rst_data",  {24'h0, rx_if.uart_rx_data}, 32'h0);
    rx_if.uart_rxd = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    n_valid = 0; n_err = 0; n_brk = 0;
    idle(200);
    check_eq("post_rst_strobes", n_valid + n_err + n_brk, 32'h0);

    // Single frame and latency.
    send_byte(8'hA5, 1'b1);
    idle(20);
    lat = last_valid_cyc - start_cyc;
    check_eq("a5_count", n_valid, 32'd1);
    check_eq("a5_data", next_word(), 32'hA5);
    check_eq("a5_err", n_err + n_brk, 32'h0);
    check_eq("a5_latency_in_range", {31'h0, (lat >= 478 && lat <= 480)}, 32'h1);

    // Back-to-back frames with no idle gap.
    v0 = n_valid;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    idle(20);
    check_eq("b2b_count", n_valid - v0, 32'd3);
    check_eq("b2b_w0", next_word(), 32'h00);
    check_eq("b2b_w1", next_word(), 32'hFF);
    check_eq("b2b_w2", next_word(), 32'h3C);
    check_eq("b2b_err", n_err + n_brk, 32'h0);

    // Start-bit glitch, then a good frame.
    v0 = n_valid;
    rx_if.uart_rxd = 1'b0;
    idle(10);
    rx_if.uart_rxd = 1'b1;
    idle(200);
    check_eq("glitch_strobes", (n_valid - v0) + n_err + n_brk, 32'h0);
    send_byte(8'h55, 1'b1);
    idle(20);
    check_eq("glitch_next_count", n_valid - v0, 32'd1);
    check_eq("glitch_next_data", next_word(), 32'h55);

    // Framing error with non-zero data.
    v0 = n_valid; e0 = n_err; b0 = n_brk;
    send_byte(8'h81, 1'b0);
    idle(100);
    check_eq("ferr_err", n_err - e0, 32'd1);
    check_eq("ferr_valid", n_valid - v0, 32'd0);
    check_eq("ferr_break", n_brk - b0, 32'd0);
    check_eq("ferr_data_held", {24'h0, rx_if.uart_rx_data}, 32'h55);

    // Line held low: a single break.
    e0 = n_err; b0 = n_brk;
    rx_if.uart_rxd = 1'b0;
    idle(2000);
    rx_if.uart_rxd = 1'b1;
    idle(200);
    check_eq("brk_err", n_err - e0, 32'd1);
    check_eq("brk_break", n_brk - b0, 32'd1);
    check_eq("brk_valid", n_valid - v0, 32'd0);
    check_eq("brk_data_held", {24'h0, rx_if.uart_rx_data}, 32'h55);
    check_eq("brk_alone", n_brk_alone, 32'd0);

    // Receiver disabled across a whole frame.
    v0 = n_valid;
    rx_if.uart_rx_en = 1'b0;
    send_byte(8'h77, 1'b1);
    idle(100);
    rx_if.uart_rx_en = 1'b1;
    idle(20);
    check_eq("en_off_valid", n_valid - v0, 32'd0);

    // Enable dropped mid-frame.
    fork
      send_byte(8'hC3, 1'b1);
      begin idle(200); rx_if.uart_rx_en = 1'b0; end
    join
    idle(20);
    rx_if.uart_rx_en = 1'b1;
    check_eq("en_drop_count", n_valid - v0, 32'd1);
    check_eq("en_drop_data", next_word(), 32'hC3);

    // Reset pulse during data bit 4 (bits 4..7 high so the tail is idle-like).
    v0 = n_valid; e0 = n_err;
    fork
      send_byte(8'hF3, 1'b1);
      begin idle(265); reset_n = 1'b0; idle(5); reset_n = 1'b1; end
    join
    idle(100);
    check_eq("rst_mid_strobes", (n_valid - v0) + (n_err - e0), 32'h0);
    check_eq("rst_mid_data", {24'h0, rx_if.uart_rx_data}, 32'h0);
    send_byte(8'h12, 1'b1);
    idle(20);
    check_eq("rst_mid_next_count", n_valid - v0, 32'd1);
    check_eq("rst_mid_next_data", next_word(), 32'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
